// File: rtl/pong_game_ctrl.sv
// Frame-synchronous pong game sequencer: frame tick, game FSM, scores, update gating.
// Optional ball speed-up on paddle hits when PONG_SPEEDUP_EN is defined.
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 120,
  parameter int unsigned SCORE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       v_vid,
  input  logic       btn_start,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       hit,
  output logic       frame_tick,
  output logic       upd_en,
  output logic       ball_reset,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic [1:0] speed
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_SCORE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] LP_WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] LP_SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] LP_SCORE_LAST = 8'(SCORE_FRAMES - 1);

  state_t     r_state, w_state_nxt;
  logic       r_v_vid_d, r_btn_d, r_frame_tick, r_upd_en, r_ball_reset;
  logic [7:0] r_frame_cnt, w_frame_cnt_nxt;
  logic [3:0] r_score_l, r_score_r, w_score_l_nxt, w_score_r_nxt;
  logic       w_start_edge, w_tick_nxt, w_upd_nxt, w_ball_reset_nxt;

  assign w_tick_nxt   = r_v_vid_d & ~v_vid;
  assign w_start_edge = btn_start & ~r_btn_d;

  // btn_d resets high so a button held through reset does not start a game
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v_vid_d    <= 1'b0;
      r_btn_d      <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_v_vid_d    <= v_vid;
      r_btn_d      <= btn_start;
      r_frame_tick <= w_tick_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_frame_cnt <= '0;
      r_score_l   <= '0;
      r_score_r   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_score_l   <= w_score_l_nxt;
      r_score_r   <= w_score_r_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_score_l_nxt   = r_score_l;
    w_score_r_nxt   = r_score_r;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt     = S_SERVE;
          w_frame_cnt_nxt = '0;
        end
      end
      S_SERVE: begin
        if (r_frame_tick) begin
          if (r_frame_cnt == LP_SERVE_LAST) begin
            w_state_nxt     = S_PLAY;
            w_frame_cnt_nxt = '0;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          end
        end
      end
      S_PLAY: begin
        // miss_left has priority; a simultaneous miss_right is dropped
        if (miss_left) begin
          w_state_nxt = S_SCORE;
          if (r_score_r < LP_WIN) w_score_r_nxt = r_score_r + 4'd1;
        end else if (miss_right) begin
          w_state_nxt = S_SCORE;
          if (r_score_l < LP_WIN) w_score_l_nxt = r_score_l + 4'd1;
        end
      end
      S_SCORE: begin
        if (r_frame_tick) begin
          if (r_frame_cnt == LP_SCORE_LAST) begin
            w_frame_cnt_nxt = '0;
            w_state_nxt = ((r_score_l == LP_WIN) || (r_score_r == LP_WIN)) ? S_OVER : S_SERVE;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          end
        end
      end
      S_OVER: begin
        if (w_start_edge) begin
          w_state_nxt     = S_SERVE;
          w_frame_cnt_nxt = '0;
          w_score_l_nxt   = '0;
          w_score_r_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they line up with state and frame_tick
  always_comb begin
    w_ball_reset_nxt = (w_state_nxt != S_PLAY);
    w_upd_nxt        = (r_state == S_PLAY) && (w_state_nxt == S_PLAY) && w_tick_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upd_en     <= 1'b0;
      r_ball_reset <= 1'b1;
    end else begin
      r_upd_en     <= w_upd_nxt;
      r_ball_reset <= w_ball_reset_nxt;
    end
  end

`ifdef PONG_SPEEDUP_EN
  logic [1:0] r_hit_cnt, r_speed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt <= '0;
      r_speed   <= '0;
    end else if ((w_state_nxt == S_SERVE) && (r_state != S_SERVE)) begin
      r_hit_cnt <= '0;
      r_speed   <= '0;
    end else if ((r_state == S_PLAY) && hit) begin
      r_hit_cnt <= r_hit_cnt + 2'd1;
      if ((r_hit_cnt == 2'd3) && (r_speed != 2'd3)) r_speed <= r_speed + 2'd1;
    end
  end

  assign speed = r_speed;
`else
  logic w_unused_hit;
  assign w_unused_hit = hit;
  assign speed        = '0;
`endif

  assign frame_tick = r_frame_tick;
  assign upd_en     = r_upd_en;
  assign ball_reset = r_ball_reset;
  assign score_l    = r_score_l;
  assign score_r    = r_score_r;
  assign state      = r_state;

endmodule
